// File: rtl/axi_rd_mem_model.sv
// AXI4 read-slave memory model: in-order AR queue, fixed read latency, FIXED/INCR bursts.
// Optional AXI_RD_MEM_MODEL_RANGE_CHK_EN returns SLVERR/zero data for beats at or beyond DP.
module axi_rd_mem_model #(
    parameter int DW          = 32,
    parameter int DP          = 1024,
    parameter int AW          = 32,
    parameter int IDW         = 4,
    parameter int OUTSTANDING = 4,
    parameter int RD_LATENCY  = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           arvalid,
    output logic           arready,
    input  logic [AW-1:0]  araddr,
    input  logic [7:0]     arlen,
    input  logic [1:0]     arburst,
    input  logic [IDW-1:0] arid,
    output logic           rvalid,
    input  logic           rready,
    output logic [DW-1:0]  rdata,
    output logic [1:0]     rresp,
    output logic           rlast,
    output logic [IDW-1:0] rid
);

    localparam int IW = $clog2(DP);
    localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CW = $clog2(OUTSTANDING + 1);
    localparam int LW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_BURST
    } state_t;

    state_t state;

    logic [IDW-1:0] q_id    [OUTSTANDING];
    logic [AW-1:0]  q_addr  [OUTSTANDING];
    logic [7:0]     q_len   [OUTSTANDING];
    logic [1:0]     q_burst [OUTSTANDING];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;

    logic [LW-1:0] lat;
    logic [7:0]    beat;
    logic [7:0]    len;
    logic          incr;
    logic [AW-1:0] cur_addr;
    logic [AW-1:0] nxt_addr;
    logic [AW-1:0] pres_addr;
    logic          oor;
    logic [DW-1:0] pres_data;
    logic [1:0]    pres_resp;

    logic push;
    logic pop;
    logic beat_hs;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign push    = arvalid && arready;
    assign pop     = (state == S_IDLE) && (count != '0);
    assign beat_hs = rvalid && rready;

    assign count_nxt = count + CW'(push) - CW'(pop);

    assign nxt_addr  = incr ? cur_addr + AW'(1) : cur_addr;
    assign pres_addr = (state == S_BURST) ? nxt_addr : cur_addr;

`ifdef AXI_RD_MEM_MODEL_RANGE_CHK_EN
    assign oor = (pres_addr >= AW'(DP));
`else
    logic addr_unused;
    assign addr_unused = ^pres_addr[AW-1:IW];
    assign oor         = 1'b0;
`endif

    // No write port: contents stay at mem[i] = i, so the word is generated.
    assign pres_data = oor ? '0 : DW'(pres_addr[IW-1:0]);
    assign pres_resp = oor ? 2'b10 : 2'b00;

    always_ff @(posedge clk) begin
        if (push) begin
            q_id[wr_ptr]    <= arid;
            q_addr[wr_ptr]  <= araddr;
            q_len[wr_ptr]   <= arlen;
            q_burst[wr_ptr] <= arburst;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            arready  <= 1'b1;
            lat      <= '0;
            beat     <= '0;
            len      <= '0;
            incr     <= 1'b0;
            cur_addr <= '0;
            rvalid   <= 1'b0;
            rlast    <= 1'b0;
            rdata    <= '0;
            rresp    <= 2'b00;
            rid      <= '0;
        end else begin
            count   <= count_nxt;
            arready <= (count_nxt < CW'(OUTSTANDING));
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            unique case (state)
                S_IDLE: begin
                    if (pop) begin
                        rd_ptr   <= ptr_inc(rd_ptr);
                        cur_addr <= q_addr[rd_ptr];
                        len      <= q_len[rd_ptr];
                        incr     <= (q_burst[rd_ptr] != 2'b00);
                        rid      <= q_id[rd_ptr];
                        beat     <= '0;
                        lat      <= LW'(RD_LATENCY - 1);
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (lat == '0) begin
                        rvalid <= 1'b1;
                        rdata  <= pres_data;
                        rresp  <= pres_resp;
                        rlast  <= (len == 8'd0);
                        state  <= S_BURST;
                    end else begin
                        lat <= lat - 1'b1;
                    end
                end
                S_BURST: begin
                    if (beat_hs) begin
                        if (rlast) begin
                            rvalid <= 1'b0;
                            rlast  <= 1'b0;
                            state  <= S_IDLE;
                        end else begin
                            cur_addr <= nxt_addr;
                            beat     <= beat + 8'd1;
                            rdata    <= pres_data;
                            rresp    <= pres_resp;
                            rlast    <= ((beat + 8'd1) == len);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_mem_model.sv
// Directed bench for axi_rd_mem_model: latency, bursts, back-pressure, ordering, reset abort.
// Expectations follow AXI_RD_MEM_MODEL_RANGE_CHK_EN when it is defined.
module tb_axi_rd_mem_model;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [1:0]  arburst;
    logic [3:0]  arid;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;

    int vecs = 0;
    int errs = 0;

    axi_rd_mem_model dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .arvalid (arvalid),
        .arready (arready),
        .araddr  (araddr),
        .arlen   (arlen),
        .arburst (arburst),
        .arid    (arid),
        .rvalid  (rvalid),
        .rready  (rready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rlast   (rlast),
        .rid     (rid)
    );

    initial forever #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_data(input logic [31:0] a);
`ifdef AXI_RD_MEM_MODEL_RANGE_CHK_EN
        if (a >= 32'd1024) return 32'd0;
`endif
        return a % 32'd1024;
    endfunction

    function automatic logic [31:0] exp_resp(input logic [31:0] a);
`ifdef AXI_RD_MEM_MODEL_RANGE_CHK_EN
        if (a >= 32'd1024) return 32'd2;
`endif
        return (a == 32'hffff_ffff) ? 32'd1 : 32'd0;
    endfunction

    // Returns right after the edge on which the AR handshake happened.
    task automatic send_ar(input logic [31:0] a, input logic [7:0] l,
                           input logic [1:0] b, input logic [3:0] id);
        int n = 0;
        arvalid = 1'b1;
        araddr  = a;
        arlen   = l;
        arburst = b;
        arid    = id;
        while (!arready && n < 50) begin
            tick();
            n++;
        end
        check("ar_accept", 32'(n < 50), 32'd1);
        tick();
        arvalid = 1'b0;
    endtask

    task automatic collect(input logic [31:0] base, input int nb, input bit inc,
                           input logic [3:0] id, input bit alt);
        int k = 0;
        int cyc = 0;
        bit ph = 1'b0;
        bit hv = 1'b0;
        logic [31:0] held;
        logic [31:0] a;
        while (k < nb && cyc < 200) begin
            if (hv) check("hold_rdata", rdata, held);
            hv = 1'b0;
            rready = alt ? ph : 1'b1;
            ph = !ph;
            if (rvalid && rready) begin
                a = inc ? base + 32'(k) : base;
                check("rdata", rdata, exp_data(a));
                check("rresp", 32'(rresp), exp_resp(a));
                check("rid", 32'(rid), 32'(id));
                check("rlast", 32'(rlast), 32'(k == nb - 1));
                k++;
            end else if (rvalid) begin
                held = rdata;
                hv = 1'b1;
            end
            tick();
            cyc++;
        end
        check("beats", 32'(k), 32'(nb));
        check("rvalid_drop", 32'(rvalid), 32'd0);
    endtask

    initial begin
        int n;
        rst_n   = 1'b0;
        arvalid = 1'b0;
        araddr  = '0;
        arlen   = '0;
        arburst = '0;
        arid    = '0;
        rready  = 1'b0;
        tick();
        tick();
        check("rst_rvalid", 32'(rvalid), 32'd0);
        rst_n = 1'b1;
        tick();
        check("rel_arready", 32'(arready), 32'd1);
        check("rel_rvalid", 32'(rvalid), 32'd0);
        check("rel_rlast", 32'(rlast), 32'd0);
        check("rel_rdata", rdata, 32'd0);
        check("rel_rid", 32'(rid), 32'd0);

        // Latency and INCR burst with rready held high.
        rready = 1'b1;
        send_ar(32'd16, 8'd3, 2'd1, 4'd5);
        check("lat_n0", 32'(rvalid), 32'd0);
        tick();
        check("lat_n1", 32'(rvalid), 32'd0);
        tick();
        check("lat_n2", 32'(rvalid), 32'd0);
        tick();
        check("lat_n3", 32'(rvalid), 32'd1);
        check("b0_data", rdata, 32'd16);
        check("b0_rid", 32'(rid), 32'd5);
        check("b0_last", 32'(rlast), 32'd0);
        tick();
        check("b1_data", rdata, 32'd17);
        check("b1_last", 32'(rlast), 32'd0);
        tick();
        check("b2_data", rdata, 32'd18);
        tick();
        check("b3_data", rdata, 32'd19);
        check("b3_last", 32'(rlast), 32'd1);
        check("b3_rid", 32'(rid), 32'd5);
        tick();
        check("end_rvalid", 32'(rvalid), 32'd0);

        // Same burst under alternating back-pressure.
        rready = 1'b0;
        send_ar(32'd16, 8'd3, 2'd1, 4'd5);
        collect(32'd16, 4, 1'b1, 4'd5, 1'b1);

        // Five single-beat requests while rready is low.
        rready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_ar(32'(i), 8'd0, 2'd1, 4'(i));
        end
        check("q_full_arready", 32'(arready), 32'd0);
        tick();
        check("q_full_hold", 32'(arready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            collect(32'(i), 1, 1'b1, 4'(i), 1'b0);
        end
        tick();
        check("q_drain_arready", 32'(arready), 32'd1);

        // FIXED burst, then INCR across the top of memory.
        send_ar(32'd5, 8'd2, 2'd0, 4'd7);
        collect(32'd5, 3, 1'b0, 4'd7, 1'b0);
        send_ar(32'd1022, 8'd3, 2'd1, 4'd3);
        collect(32'd1022, 4, 1'b1, 4'd3, 1'b0);

        // Reset mid-burst with two requests still queued.
        rready = 1'b0;
        send_ar(32'd100, 8'd7, 2'd1, 4'd9);
        send_ar(32'd200, 8'd0, 2'd1, 4'd1);
        send_ar(32'd300, 8'd0, 2'd1, 4'd2);
        n = 0;
        while (!rvalid && n < 50) begin
            tick();
            n++;
        end
        check("abort_start", 32'(rvalid), 32'd1);
        rready = 1'b1;
        tick();
        tick();
        check("abort_b2_data", rdata, 32'd102);
        check("abort_b2_rid", 32'(rid), 32'd9);
        rst_n = 1'b0;
        #1;
        check("abort_rvalid", 32'(rvalid), 32'd0);
        check("abort_rlast", 32'(rlast), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("abort_arready", 32'(arready), 32'd1);
        for (int i = 0; i < 10; i++) begin
            check("abort_quiet", 32'(rvalid), 32'd0);
            tick();
        end
        send_ar(32'd42, 8'd0, 2'd1, 4'd3);
        collect(32'd42, 1, 1'b1, 4'd3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
